regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised successor to the single-cycle CPU register file, intended for the pipelined CPU.
- Provides two combinational read ports and one write port, with a write-to-read bypass so a same-cycle read returns the data being written.
- Holds a per-register pending-write counter (scoreboard). Decode marks a destination register as pending at issue; writeback retires it. Hazard logic reads the busy flags to stall.
- Writes occur on the rising edge of clk; there is no negedge write.

Parameters:
- DATA_W, 32, data width of every register.
- REG_CNT, 32, number of architectural registers.
- ADDR_W, 5, register index width. Must satisfy 2**ADDR_W >= REG_CNT.
- PEND_W, 2, width of each pending counter. Maximum outstanding writes per register is 2**PEND_W-1.

Ports:
- clk, input, 1, clock. All state updates on the rising edge.
- rst, input, 1, reset. Synchronous, active-high.
- regWrite, input, 1, write enable for the writeback port.
- write_register, input, ADDR_W, writeback destination index.
- write_data, input, DATA_W, writeback data.
- read_register_1, input, ADDR_W, read port 1 index.
- read_register_2, input, ADDR_W, read port 2 index.
- read_data_1, output, DATA_W, read port 1 data (combinational).
- read_data_2, output, DATA_W, read port 2 data (combinational).
- read_busy_1, output, 1, read port 1 register has an outstanding write.
- read_busy_2, output, 1, read port 2 register has an outstanding write.
- issue_valid, input, 1, decode reserves issue_register as a destination.
- issue_register, input, ADDR_W, index being reserved.
- issue_ready, output, 1, reservation can be accepted this cycle.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset:
  - On a rising edge with rst=1, every register becomes 0 and every pending counter becomes 0.
  - issue_valid and regWrite are ignored in that cycle.
  - While rst=1, the bypass is disabled; read_data_* show stored contents and issue_ready=0.
  - After the reset edge: read_data_*=0, read_busy_*=0, issue_ready=1.
- Write:
  - Condition: regWrite=1, rst=0, write_register < REG_CNT.
  - At the rising edge, mem[write_register] <= write_data.
  - Writes to an index >= REG_CNT are ignored.
- Read:
  - Zero latency.
  - If regWrite=1, rst=0 and read_register_n == write_register (a valid index), then read_data_n = write_data (bypass).
  - Otherwise read_data_n = mem[read_register_n].
  - An index >= REG_CNT reads 0.
- Pending counters, cnt[r]:
  - inc = issue_valid & issue_ready & (issue_register == r).
  - dec = regWrite & (write_register == r) & (cnt[r] != 0).
  - Next value: cnt[r] + inc - dec.
  - Simultaneous inc and dec on the same r leaves the count unchanged.
  - A write to a register with cnt=0 does not underflow; the data is still written.
- issue_ready:
  - 0 if rst=1, or issue_register >= REG_CNT, or cnt[issue_register] is at maximum and no dec on that register this cycle.
  - 1 otherwise.
  - A refused issue changes nothing.
- read_busy_n:
  - Equals (cnt[read_register_n] - dec_this_cycle) != 0, i.e. a retiring write in the same cycle is already visible.
  - A same-cycle issue is not reflected until the next cycle.
  - An index >= REG_CNT gives busy 0.
- No other state. Implementation target is ~150-250 lines.

Optional Feature:
- Macro: REGFILE_ZERO_HARDWIRE_EN.
- Defined:
  - Register 0 always reads 0, including via the bypass.
  - Writes to index 0 are discarded.
  - cnt[0] is never incremented; issue to index 0 is accepted (issue_ready=1) with no effect.
  - read_busy for index 0 is always 0.
- Undefined: register 0 is an ordinary register.

Test Plan:
1. Reset: write 0xDEADBEEF to r5, then assert rst one cycle -> read r5 = 0, all busy = 0, issue_ready = 1 after the edge; during the rst cycle issue_ready = 0.
2. Bypass: regWrite=1, write r7 = 0x12345678, read_register_1 = 7 in the same cycle -> read_data_1 = 0x12345678 before the edge; after the edge, regWrite=0 still reads 0x12345678.
3. Scoreboard saturation (PEND_W=2): issue r3 four times in consecutive cycles -> the first three are accepted; the fourth sees issue_ready = 0 and read_busy = 1. Then write r3 while issuing r3 -> issue_ready = 1 and the count stays at 3. Three further writes -> busy = 0.
4. Retire visibility: cnt[9] = 1, write r9 with read_register_2 = 9 -> read_busy_2 = 0 in the same cycle and read_data_2 = write_data. A write to r9 with cnt = 0 -> count stays 0.
5. Reset mid-operation: cnt[4] = 2 and regWrite to r4 asserted together with rst -> after the edge cnt[4] = 0 and r4 = 0.
6. Zero register: with REGFILE_ZERO_HARDWIRE_EN defined, write r0 = 0xFFFFFFFF -> read r0 = 0 in the same cycle and the next, and busy stays 0. Without the macro, r0 reads 0xFFFFFFFF.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2R/1W register file with write-to-read bypass and per-register pending-write scoreboard (option REGFILE_ZERO_HARDWIRE_EN hardwires r0 to zero)
// Ports: clk, rst (sync, active-high); regWrite/write_register/write_data writeback port;
// read_register_n -> read_data_n, read_busy_n combinational read ports; issue_valid/issue_register -> issue_ready reservation.
module regfile_scoreboard #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32,
  parameter int ADDR_W  = 5,
  parameter int PEND_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] write_register,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_register_1,
  input  logic [ADDR_W-1:0] read_register_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic              read_busy_1,
  output logic              read_busy_2,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_register,
  output logic              issue_ready
);
`ifdef REGFILE_ZERO_HARDWIRE_EN
  localparam bit ZH = 1'b1;
`else
  localparam bit ZH = 1'b0;
`endif
  localparam logic [ADDR_W:0] CNT_L = (ADDR_W+1)'(REG_CNT);
  localparam logic [PEND_W-1:0] MAX = '1;
  logic [DATA_W-1:0] mem [REG_CNT];
  logic [PEND_W-1:0] cnt [REG_CNT];
  logic [REG_CNT-1:0] inc, dec;
  logic wr_ok;
  function automatic logic ok(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < CNT_L;
  endfunction
  function automatic logic zero(input logic [ADDR_W-1:0] a);
    return ZH && a == '0;
  endfunction
  assign wr_ok = regWrite & ~rst & ok(write_register) & ~zero(write_register);
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    return (!ok(a) || zero(a)) ? '0 : (wr_ok && a == write_register) ? write_data : mem[a];
  endfunction
  // a write retiring this cycle already clears busy
  function automatic logic busy(input logic [ADDR_W-1:0] a);
    return (ok(a) && !zero(a)) ? ((cnt[a] - PEND_W'(dec[a])) != '0) : 1'b0;
  endfunction
  assign read_data_1 = rd(read_register_1);
  assign read_data_2 = rd(read_register_2);
  assign read_busy_1 = busy(read_register_1);
  assign read_busy_2 = busy(read_register_2);
  assign issue_ready = ~rst & ok(issue_register) &
                       (zero(issue_register) | cnt[issue_register] != MAX | dec[issue_register]);
  always_comb begin
    dec = '0;
    for (int r = 0; r < REG_CNT; r++)
      dec[r] = regWrite & write_register == ADDR_W'(r) & cnt[r] != '0;
  end
  always_comb begin
    inc = '0;
    for (int r = 0; r < REG_CNT; r++)
      inc[r] = issue_valid & issue_ready & issue_register == ADDR_W'(r) & ~zero(ADDR_W'(r));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < REG_CNT; r++) begin
        mem[r] <= '0;
        cnt[r] <= '0;
      end
    end else begin
      if (wr_ok) mem[write_register] <= write_data;
      for (int r = 0; r < REG_CNT; r++)
        cnt[r] <= cnt[r] + PEND_W'(inc[r]) - PEND_W'(dec[r]);
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: scoreboard bench for regfile_scoreboard against a behavioural register-file model
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b0, regWrite = 1'b0, issue_valid = 1'b0;
  logic [4:0] write_register = '0, read_register_1 = '0, read_register_2 = '0, issue_register = '0;
  logic [31:0] write_data = '0, read_data_1, read_data_2;
  logic read_busy_1, read_busy_2, issue_ready;
  regfile_scoreboard dut (
    .clk(clk), .rst(rst), .regWrite(regWrite), .write_register(write_register),
    .write_data(write_data), .read_register_1(read_register_1), .read_register_2(read_register_2),
    .read_data_1(read_data_1), .read_data_2(read_data_2), .read_busy_1(read_busy_1),
    .read_busy_2(read_busy_2), .issue_valid(issue_valid), .issue_register(issue_register),
    .issue_ready(issue_ready)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] d1, d2;
    logic b1, b2, rdy, in_rst;
  } exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0;
`ifdef REGFILE_ZERO_HARDWIRE_EN
  localparam bit ZH = 1'b1;
`else
  localparam bit ZH = 1'b0;
`endif
  logic [31:0] m_mem [32];
  int m_cnt [32];
  function automatic logic [31:0] m_read(int a, bit r, bit we, int wr, logic [31:0] wd);
    if (ZH && a == 0) return 32'h0;
    if (!r && we && a == wr) return wd;
    return m_mem[a];
  endfunction
  function automatic logic m_busy(int a, bit we, int wr);
    int c;
    if (ZH && a == 0) return 1'b0;
    c = m_cnt[a];
    if (we && wr == a && c > 0) c--;
    return c != 0;
  endfunction
  task automatic step(bit r, bit we, int wr, logic [31:0] wd, int r1, int r2, bit iv, int ii);
    exp_t e;
    bit rdy, dec;
    @(negedge clk);
    rst = r; regWrite = we; write_register = wr[4:0]; write_data = wd;
    read_register_1 = r1[4:0]; read_register_2 = r2[4:0];
    issue_valid = iv; issue_register = ii[4:0];
    dec = we && m_cnt[wr] > 0;
    rdy = !r && ((ZH && ii == 0) || m_cnt[ii] < 3 || (dec && wr == ii));
    e.d1 = m_read(r1, r, we, wr, wd);
    e.d2 = m_read(r2, r, we, wr, wd);
    e.b1 = m_busy(r1, we, wr);
    e.b2 = m_busy(r2, we, wr);
    e.rdy = rdy;
    e.in_rst = r;
    q.push_back(e);
    if (r) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i] = 32'h0;
        m_cnt[i] = 0;
      end
    end else begin
      if (we && !(ZH && wr == 0)) m_mem[wr] = wd;
      if (dec) m_cnt[wr]--;
      if (iv && rdy && !(ZH && ii == 0)) m_cnt[ii]++;
    end
  endtask
  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() != 0) begin
        e = q.pop_front();
        vectors++;
        chk("issue_ready", {31'b0, issue_ready}, {31'b0, e.rdy});
        if (!e.in_rst) begin
          chk("read_data_1", read_data_1, e.d1);
          chk("read_data_2", read_data_2, e.d2);
          chk("read_busy_1", {31'b0, read_busy_1}, {31'b0, e.b1});
          chk("read_busy_2", {31'b0, read_busy_2}, {31'b0, e.b2});
        end
      end
    end
  end
  initial begin : driver
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = 32'h0;
      m_cnt[i] = 0;
    end
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 5, 0, 1, 2);
    step(0, 1, 5, 32'hDEADBEEF, 5, 5, 0, 0);
    step(0, 0, 0, 0, 5, 2, 0, 0);
    step(1, 1, 5, 32'h1, 5, 2, 1, 1);
    step(0, 0, 0, 0, 5, 1, 1, 2);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 7, 32'h12345678, 7, 0, 0, 0);
    step(0, 0, 0, 0, 7, 7, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 3, 3, 1, 3);
    step(0, 1, 3, 32'hA, 3, 3, 1, 3);
    for (int i = 0; i < 3; i++) step(0, 1, 3, 32'hB + i, 3, 3, 0, 0);
    step(0, 0, 0, 0, 3, 3, 0, 0);
    step(0, 0, 0, 0, 9, 9, 1, 9);
    step(0, 1, 9, 32'h99, 1, 9, 0, 0);
    step(0, 1, 9, 32'h98, 9, 9, 0, 0);
    step(0, 0, 0, 0, 9, 9, 1, 9);
    step(0, 0, 0, 0, 4, 4, 1, 4);
    step(0, 0, 0, 0, 4, 4, 1, 4);
    step(1, 1, 4, 32'h44, 4, 4, 0, 0);
    step(0, 0, 0, 0, 4, 4, 1, 4);
    step(0, 1, 0, 32'hFFFFFFFF, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 500; n++) begin
      int wr, r1, r2, ii;
      wr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
      r1 = $urandom_range(0, 7);
      r2 = ($urandom_range(0, 1) == 0) ? wr : $urandom_range(0, 31);
      ii = $urandom_range(0, 7);
      step($urandom_range(0, 79) == 0, $urandom_range(0, 1) == 1, wr, $urandom,
           r1, r2, $urandom_range(0, 2) != 0, ii);
    end
    @(negedge clk);
    #5;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
